// File: rtl/labyrinth_pkg.sv
// Shared PS/2 scancodes, decoder state encoding and direction indices.
// Pure definitions, no latency.
// No flow control; consumers use these types directly.
package labyrinth_pkg;

  // Set-2 scancodes used by the arrow decoder
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  // Prefix-tracking states of the scancode parser
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXT    = 2'd1,
    ST_BRK    = 2'd2,
    ST_EXTBRK = 2'd3
  } kbd_state_e;

  // Direction index doubles as the bit position in the hold/move vectors
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef struct packed {
    logic vld;
    dir_e dir;
  } arrow_t;

  // Map a scancode to an arrow direction; vld=0 for any non-arrow code
  function automatic arrow_t decode_arrow(input logic [7:0] code);
    arrow_t r;
    r.vld = 1'b1;
    r.dir = DIR_UP;
    case (code)
      SC_UP:    r.dir = DIR_UP;
      SC_DOWN:  r.dir = DIR_DOWN;
      SC_LEFT:  r.dir = DIR_LEFT;
      SC_RIGHT: r.dir = DIR_RIGHT;
      default:  r.vld = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] dir_onehot(input dir_e d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/typematic_timer.sv
// Auto-repeat timer: first fire REPEAT_DELAY cycles after start, then every REPEAT_PERIOD.
// fire_o is combinational from the count; the caller registers it (one cycle to output).
// start/stop take priority over an expiry in the same cycle; no backpressure.
module typematic_timer
  import labyrinth_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic stop_i,
  input  logic hold_i,
  output logic fire_o
);

  // The count holds "cycles remaining minus one", so the larger parameter
  // fits in $clog2 bits and expiry is simply count==0. Both parameters must be >= 1.
  localparam int unsigned MAX_P = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;
  localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A fresh press or a release of the active key swallows a coincident expiry
  assign fire_o = hold_i && !start_i && !stop_i && (cnt_q == '0);

  // Next count: load delay on start, park at 0 on stop, else count down and reload period
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = DELAY_LD;
    end else if (stop_i) begin
      cnt_d = '0;
    end else if (hold_i) begin
      if (cnt_q == '0) begin
        cnt_d = PERIOD_LD;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_arrow_decoder.sv
// PS/2 set-2 arrow/Enter decoder with per-key hold flags and auto-repeat of the last pressed arrow.
// One cycle from the completing iDataEn byte to the registered pulse; repeats every REPEAT_PERIOD.
// No backpressure: every strobed byte is consumed in the cycle it arrives.
module ps2_arrow_decoder
  import labyrinth_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic [7:0] iData,
  input  logic       iDataEn,
  output logic       oUp,
  output logic       oDown,
  output logic       oLeft,
  output logic       oRight,
  output logic       oEnter,
  output logic [3:0] oHeld
);

  kbd_state_e state_q;
  logic [3:0] held_q;
  logic [3:0] move_q;
  logic       enter_q;
  logic       active_vld_q;
  dir_e       active_q;

  arrow_t     arrow;
  logic       press;
  logic       release_active;
  logic       tmr_fire;

  // Classify the incoming byte: a new (non-typematic) arrow make, or a break of the active key
  always_comb begin
    arrow          = decode_arrow(iData);
    press          = 1'b0;
    release_active = 1'b0;
    if (iDataEn && arrow.vld) begin
      if (state_q == ST_EXT && !held_q[arrow.dir]) begin
        press = 1'b1;
      end
      if (state_q == ST_EXTBRK && active_vld_q && (active_q == arrow.dir)) begin
        release_active = 1'b1;
      end
    end
  end

  typematic_timer #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_timer (
    .clk_i  (iClock),
    .rst_i  (iReset),
    .start_i(press),
    .stop_i (release_active),
    .hold_i (active_vld_q),
    .fire_o (tmr_fire)
  );

  // Prefix FSM with registered pulse outputs, hold flags and active-key tracking
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q      <= ST_IDLE;
      held_q       <= '0;
      move_q       <= '0;
      enter_q      <= 1'b0;
      active_vld_q <= 1'b0;
      active_q     <= DIR_UP;
    end else begin
      move_q  <= '0;
      enter_q <= 1'b0;
      // Timer already masks expiry when a press or active release happens this cycle
      if (tmr_fire) begin
        move_q <= dir_onehot(active_q);
      end
      if (iDataEn) begin
        case (state_q)
          ST_IDLE: begin
            if (iData == SC_EXT) begin
              state_q <= ST_EXT;
            end else if (iData == SC_BRK) begin
              state_q <= ST_BRK;
            end else begin
              state_q <= ST_IDLE;
              if (iData == SC_ENTER) begin
                enter_q <= 1'b1;
              end
            end
          end
          ST_EXT: begin
            if (iData == SC_EXT) begin
              state_q <= ST_EXT;
            end else if (iData == SC_BRK) begin
              state_q <= ST_EXTBRK;
            end else begin
              state_q <= ST_IDLE;
              // Typematic re-makes of a held key fall through silently
              if (press) begin
                held_q[arrow.dir] <= 1'b1;
                move_q            <= dir_onehot(arrow.dir);
                active_q          <= arrow.dir;
                active_vld_q      <= 1'b1;
              end
            end
          end
          ST_BRK: begin
            // Unprefixed break (keypad arrows, Enter, anything else): nothing to do
            state_q <= ST_IDLE;
          end
          ST_EXTBRK: begin
            state_q <= ST_IDLE;
            if (arrow.vld) begin
              held_q[arrow.dir] <= 1'b0;
            end
            // Releasing the active key ends repeat; other held keys do not take over
            if (release_active) begin
              active_vld_q <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign oUp    = move_q[DIR_UP];
  assign oDown  = move_q[DIR_DOWN];
  assign oLeft  = move_q[DIR_LEFT];
  assign oRight = move_q[DIR_RIGHT];
  assign oEnter = enter_q;
  assign oHeld  = held_q;

endmodule
